uart_pkt_parser: RTL and testbench

Framed-packet parser that sits directly downstream of the UART receiver and consumes its one-cycle byte strobes. It hunts for a start-of-frame byte, captures a length-prefixed payload into an internal buffer, and checks an XOR checksum. Good packets are replayed on a valid/ready byte stream to the command layer; bad or stalled packets are discarded with an error pulse.

---
 rtl/uart_pkt_pkg.sv | 18 +
 rtl/uart_pkt_buf.sv | 22 ++
 rtl/uart_pkt_parser.sv | 154 +++++++++++++++
 tb/tb_uart_pkt_parser.sv | 300 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkt_pkg.sv
// rtl/uart_pkt_pkg.sv - shared states, error codes and defaults for the UART packet parser
package uart_pkt_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LEN,
    ST_PAYLOAD,
    ST_CHK,
    ST_DRAIN
  } state_t;

  localparam logic [1:0] ERR_LEN = 2'b01;
  localparam logic [1:0] ERR_CHK = 2'b10;
  localparam logic [1:0] ERR_TMO = 2'b11;

  localparam logic [7:0] SOF_DEFAULT = 8'hA5;

endpackage

// File: rtl/uart_pkt_buf.sv
// rtl/uart_pkt_buf.sv - payload byte store, synchronous write, combinational read
module uart_pkt_buf #(
  parameter int DEPTH = 16,
  parameter int AW    = 4
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [7:0]    wdata,
  input  logic [AW-1:0] raddr,
  output logic [7:0]    rdata
);

  logic [7:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/uart_pkt_parser.sv
// rtl/uart_pkt_parser.sv - SOF/length/XOR-checksum framer that replays good payloads on a valid/ready stream
// Optional inter-byte timeout is built when UART_PKT_TIMEOUT_EN is defined.
module uart_pkt_parser
  import uart_pkt_pkg::*;
#(
  parameter int         MAX_LEN      = 16,
  parameter logic [7:0] SOF          = SOF_DEFAULT,
  parameter int         TIMEOUT_CLKS = 8680
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       rx_dv,
  input  logic [7:0] rx_byte,
  output logic       out_valid,
  output logic [7:0] out_byte,
  output logic       out_last,
  input  logic       out_ready,
  output logic       pkt_ok,
  output logic       pkt_err,
  output logic [1:0] err_code,
  output logic [7:0] drop_cnt,
  output logic       busy
);

  localparam int LW = $clog2(MAX_LEN + 1);
  localparam int AW = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;

  if (MAX_LEN < 1 || MAX_LEN > 255 || TIMEOUT_CLKS < 2) begin : g_bad_params
    $error("uart_pkt_parser: parameter out of range");
  end

  state_t        state;
  logic [LW-1:0] len;
  logic [LW-1:0] idx;
  logic [7:0]    chk;
  logic [7:0]    rd_data;
  logic          handshake;
  logic          at_last;
  logic          tmo_hit;

  assign handshake = out_valid && out_ready;
  assign at_last   = (idx == len - LW'(1));

  uart_pkt_buf #(
    .DEPTH (MAX_LEN),
    .AW    (AW)
  ) u_buf (
    .clk   (clk),
    .we    (rx_dv && (state == ST_PAYLOAD)),
    .waddr (idx[AW-1:0]),
    .wdata (rx_byte),
    .raddr (idx[AW-1:0]),
    .rdata (rd_data)
  );

`ifdef UART_PKT_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CLKS);
  logic [TW-1:0] tmo_cnt;
  logic          in_frame;

  assign in_frame = (state == ST_LEN) || (state == ST_PAYLOAD) || (state == ST_CHK);
  assign tmo_hit  = in_frame && !rx_dv && (tmo_cnt == TW'(TIMEOUT_CLKS - 1));

  always_ff @(posedge clk) begin
    if (rst || !in_frame || rx_dv || tmo_hit) tmo_cnt <= '0;
    else                                      tmo_cnt <= tmo_cnt + TW'(1);
  end
`else
  assign tmo_hit = 1'b0;
`endif

  // Stream outputs come straight from registered state and the stable buffer, so a
  // handshake can advance idx and present the next byte in the very next cycle.
  assign out_valid = (state == ST_DRAIN);
  assign out_byte  = out_valid ? rd_data : 8'h00;
  assign out_last  = out_valid && at_last;
  assign busy      = (state != ST_IDLE);

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= ST_IDLE;
      len      <= '0;
      idx      <= '0;
      chk      <= '0;
      pkt_ok   <= 1'b0;
      pkt_err  <= 1'b0;
      err_code <= 2'b00;
      drop_cnt <= '0;
    end else begin
      pkt_ok  <= 1'b0;
      pkt_err <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (rx_dv && rx_byte == SOF) state <= ST_LEN;
        end
        ST_LEN: begin
          if (tmo_hit) begin
            pkt_err  <= 1'b1;
            err_code <= ERR_TMO;
            state    <= ST_IDLE;
          end else if (rx_dv) begin
            if (rx_byte == 8'h00 || rx_byte > 8'(MAX_LEN)) begin
              pkt_err  <= 1'b1;
              err_code <= ERR_LEN;
              state    <= ST_IDLE;
            end else begin
              len   <= rx_byte[LW-1:0];
              chk   <= rx_byte;
              idx   <= '0;
              state <= ST_PAYLOAD;
            end
          end
        end
        ST_PAYLOAD: begin
          if (tmo_hit) begin
            pkt_err  <= 1'b1;
            err_code <= ERR_TMO;
            state    <= ST_IDLE;
          end else if (rx_dv) begin
            chk <= chk ^ rx_byte;
            idx <= idx + LW'(1);
            if (idx + LW'(1) == len) state <= ST_CHK;
          end
        end
        ST_CHK: begin
          if (tmo_hit) begin
            pkt_err  <= 1'b1;
            err_code <= ERR_TMO;
            state    <= ST_IDLE;
          end else if (rx_dv) begin
            if (rx_byte == chk) begin
              pkt_ok <= 1'b1;
              idx    <= '0;
              state  <= ST_DRAIN;
            end else begin
              pkt_err  <= 1'b1;
              err_code <= ERR_CHK;
              state    <= ST_IDLE;
            end
          end
        end
        ST_DRAIN: begin
          if (rx_dv && drop_cnt != 8'hFF) drop_cnt <= drop_cnt + 8'd1;
          if (handshake) begin
            if (at_last) state <= ST_IDLE;
            else         idx   <= idx + LW'(1);
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_pkt_parser.sv
// tb/tb_uart_pkt_parser.sv - randomized and directed bench with a packet-level reference model
module tb_uart_pkt_parser;

  localparam int MAX_LEN = 16;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       rx_dv = 1'b0;
  logic [7:0] rx_byte = 8'h00;
  logic       out_valid, out_last, out_ready, pkt_ok, pkt_err, busy;
  logic [7:0] out_byte, drop_cnt;
  logic [1:0] err_code;

  logic rdy_rand = 1'b0;
  logic rdy_man = 1'b1;
  logic rdy_rnd_q = 1'b1;
  assign out_ready = rdy_rand ? rdy_rnd_q : rdy_man;

  int n_cmp = 0;
  int n_fail = 0;
  int exp_evt[$];
  logic [8:0] exp_str[$];
  int drop_model = 0;

  always #5 clk = ~clk;

  uart_pkt_parser #(.MAX_LEN(MAX_LEN), .SOF(8'hA5), .TIMEOUT_CLKS(8680)) dut (
    .clk(clk), .rst(rst), .rx_dv(rx_dv), .rx_byte(rx_byte),
    .out_valid(out_valid), .out_byte(out_byte), .out_last(out_last), .out_ready(out_ready),
    .pkt_ok(pkt_ok), .pkt_err(pkt_err), .err_code(err_code), .drop_cnt(drop_cnt), .busy(busy)
  );

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_byte(input logic [7:0] b);
    rx_dv = 1'b1;
    rx_byte = b;
    tick();
    rx_dv = 1'b0;
  endtask

  task automatic gap(input int gmax);
    repeat ($urandom_range(0, gmax)) tick();
  endtask

  // Reference: a packet either fails on its length, fails on its checksum, or
  // yields its payload verbatim with the last byte flagged.
  task automatic send_pkt(input logic [7:0] len_b, input logic [7:0] pl[$],
                          input logic [7:0] chk_b, input int gmax);
    logic [7:0] model_chk;
    send_byte(8'hA5);
    gap(gmax);
    if (len_b == 8'h00 || int'(len_b) > MAX_LEN) begin
      exp_evt.push_back(1);
      send_byte(len_b);
      return;
    end
    send_byte(len_b);
    model_chk = len_b;
    for (int i = 0; i < int'(len_b); i++) begin
      gap(gmax);
      model_chk = model_chk ^ pl[i];
      send_byte(pl[i]);
    end
    gap(gmax);
    if (chk_b == model_chk) begin
      exp_evt.push_back(0);
      for (int i = 0; i < int'(len_b); i++)
        exp_str.push_back({(i == int'(len_b) - 1), pl[i]});
    end else begin
      exp_evt.push_back(2);
    end
    send_byte(chk_b);
  endtask

  task automatic wait_idle(input string name);
    int n = 0;
    while (busy === 1'b1 && n < 1000) begin
      tick();
      n++;
    end
    check(name, busy, 1'b0);
  endtask

  always @(posedge clk) begin
    #1;
    rdy_rnd_q = ($urandom_range(0, 3) != 0);
  end

  logic       prev_stall = 1'b0;
  logic [7:0] prev_byte = 8'h00;
  int         e_tmp;
  logic [8:0] s_tmp;

  always @(negedge clk) begin
    if (rst) begin
      prev_stall = 1'b0;
    end else begin
      if (prev_stall) begin
        check("stall_valid", out_valid, 1'b1);
        check("stall_byte", out_byte, prev_byte);
      end
      if (pkt_ok || pkt_err) begin
        if (exp_evt.size() == 0) begin
          check("unexpected_evt", {pkt_ok, pkt_err}, 2'b00);
        end else begin
          e_tmp = exp_evt.pop_front();
          if (e_tmp == 0) begin
            check("evt_ok", {pkt_ok, pkt_err}, 2'b10);
            check("ok_first_valid", out_valid, 1'b1);
          end else begin
            check("evt_err", {pkt_ok, pkt_err}, 2'b01);
            check("err_code", err_code, e_tmp);
          end
        end
      end
      if (out_valid && out_ready) begin
        if (exp_str.size() == 0) begin
          check("unexpected_byte", {out_last, out_byte}, 9'h000);
        end else begin
          s_tmp = exp_str.pop_front();
          check("stream", {out_last, out_byte}, s_tmp);
        end
      end
      prev_stall = out_valid && !out_ready;
      prev_byte = out_byte;
    end
  end

  initial begin
    logic [7:0] pl[$];
    logic [7:0] none[$];
    logic [7:0] b, ln, ck;
    int kind, n;

    repeat (3) tick();
    check("rst_out_valid", out_valid, 1'b0);
    check("rst_busy", busy, 1'b0);
    check("rst_pulses", {pkt_ok, pkt_err, out_last}, 3'b000);
    check("rst_out_byte", out_byte, 8'h00);
    check("rst_err_code", err_code, 2'b00);
    check("rst_drop_cnt", drop_cnt, 8'h00);
    rst = 1'b0;
    tick();

    // Reference packet, continuous ready.
    pl = '{8'h11, 8'h22, 8'h33};
    send_pkt(8'h03, pl, 8'h03, 0);
    @(negedge clk);
    check("t1_ok", {pkt_ok, out_valid, out_byte}, {2'b11, 8'h11});
    @(negedge clk);
    check("t1_b1", {out_last, out_byte}, {1'b0, 8'h22});
    @(negedge clk);
    check("t1_b2", {out_last, out_byte}, {1'b1, 8'h33});
    @(negedge clk);
    check("t1_idle", busy, 1'b0);

    send_pkt(8'h03, pl, 8'h04, 0);
    @(negedge clk);
    check("t2_err", {pkt_err, err_code, out_valid}, {1'b1, 2'b10, 1'b0});
    wait_idle("t2_idle");

    send_pkt(8'h00, none, 8'h00, 0);
    @(negedge clk);
    check("t3_len0", {pkt_err, err_code}, {1'b1, 2'b01});
    send_pkt(8'h11, none, 8'h00, 0);
    @(negedge clk);
    check("t3_len17", {pkt_err, err_code}, {1'b1, 2'b01});
    pl = '{8'h5A, 8'h01};
    send_pkt(8'h02, pl, 8'h59, 1);
    wait_idle("t3_idle");

    // Stall pattern 1,0,0,1 with two strobes during the drain.
    rdy_man = 1'b1;
    pl = '{8'hAA, 8'hBB, 8'hCC};
    send_pkt(8'h03, pl, 8'hDE, 0);
    tick();
    rdy_man = 1'b0;
    rx_dv = 1'b1;
    rx_byte = 8'hA5;
    tick();
    rx_byte = 8'h3C;
    tick();
    rx_dv = 1'b0;
    rdy_man = 1'b1;
    drop_model = 2;
    wait_idle("t4_idle");
    check("t4_drop", drop_cnt, 8'd2);

    // Strobe coincident with the final handshake is dropped, even if it is SOF.
    pl = '{8'h5A};
    send_pkt(8'h01, pl, 8'h5B, 0);
    send_byte(8'hA5);
    drop_model++;
    check("t5_idle", busy, 1'b0);
    check("t5_drop", drop_cnt, drop_model);
    pl = '{8'h10, 8'h20};
    send_pkt(8'h02, pl, 8'h32, 0);
    wait_idle("t5_next_idle");

    // Drop counter saturation.
    rdy_man = 1'b0;
    pl = '{8'h77};
    send_pkt(8'h01, pl, 8'h76, 0);
    for (int i = 0; i < 260; i++) send_byte(8'($urandom));
    drop_model = 255;
    check("t6_sat", drop_cnt, 8'd255);
    rdy_man = 1'b1;
    wait_idle("t6_idle");

    // Randomized traffic with random consumer back-pressure.
    rdy_rand = 1'b1;
    for (int p = 0; p < 40; p++) begin
      repeat ($urandom_range(0, 2)) begin
        b = 8'($urandom);
        if (b == 8'hA5) b = 8'h00;
        send_byte(b);
        gap(2);
      end
      kind = $urandom_range(0, 9);
      ln = 8'($urandom_range(1, MAX_LEN));
      if (kind == 0) ln = ($urandom_range(0, 1) == 0) ? 8'h00 : 8'($urandom_range(MAX_LEN + 1, 255));
      pl.delete();
      ck = ln;
      for (int i = 0; i < int'(ln) && i < MAX_LEN; i++) begin
        pl.push_back(8'($urandom));
        ck = ck ^ pl[i];
      end
      if (kind == 1 || kind == 2) ck = ck ^ 8'($urandom_range(1, 255));
      send_pkt(ln, pl, ck, 3);
      wait_idle("rand_idle");
    end
    rdy_rand = 1'b0;
    rdy_man = 1'b1;
    tick();

`ifdef UART_PKT_TIMEOUT_EN
    send_byte(8'hA5);
    send_byte(8'h02);
    exp_evt.push_back(3);
    send_byte(8'h44);
    n = 0;
    while (pkt_err !== 1'b1 && n < 9000) begin
      tick();
      n++;
    end
    check("tmo_clks", n, 8680);
    check("tmo_code", err_code, 2'b11);
    tick();
    check("tmo_idle", busy, 1'b0);
`else
    send_byte(8'hA5);
    send_byte(8'h02);
    send_byte(8'h44);
    n = 0;
    repeat (9000) tick();
    check("no_tmo_busy", busy, 1'b1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    drop_model = 0;
`endif

    // Reset mid-payload, after leading garbage.
    send_byte(8'h00);
    send_byte(8'hFF);
    send_byte(8'hA5);
    send_byte(8'h03);
    send_byte(8'h11);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    drop_model = 0;
    check("rst_mid_busy", {busy, pkt_err}, 2'b00);
    tick();
    check("rst_mid_noerr", {busy, pkt_err, pkt_ok}, 3'b000);
    pl = '{8'h11, 8'h22, 8'h33};
    send_pkt(8'h03, pl, 8'h03, 0);
    wait_idle("rst_recover_idle");
    check("final_drop", drop_cnt, drop_model);

    repeat (5) tick();
    check("evt_left", exp_evt.size(), 0);
    check("bytes_left", exp_str.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
